bcd_serial_alu: RTL
===================

BCD_SERIAL_ALU -- requirements
Module: bcd_serial_alu

Interface
REQ-001 The block SHALL have parameter DIGITS, default 8, giving the number of BCD digits per operand (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation on the current inputs.
REQ-005 The block SHALL have port A, input, 4*DIGITS bits: BCD magnitude of operand a.
REQ-006 The block SHALL have port B, input, 4*DIGITS bits: BCD magnitude of operand b.
REQ-007 The block SHALL have port S_a, input, 1 bit: sign of a (1 = negative).
REQ-008 The block SHALL have port S_b, input, 1 bit: sign of b (1 = negative).
REQ-009 The block SHALL have port OP, input, 1 bit: 0 = a+b, 1 = a-b.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the results are valid.
REQ-012 The block SHALL have port S, output, 4*DIGITS bits: BCD magnitude of the result.
REQ-013 The block SHALL have port Flag_S, output, 1 bit: sign of the result (1 = negative).
REQ-014 The block SHALL have port Flag_OV, output, 1 bit: magnitude overflow (carry out of the top digit).
REQ-015 The block SHALL have port Flag_INV, output, 1 bit: an operand digit exceeded 9.

Function
REQ-016 In IDLE, start=1 SHALL register A, B, S_a, S_b and OP, and the block SHALL set busy=1 on the next cycle; start while busy=1 SHALL be ignored.
REQ-017 The effective operation SHALL be eff_sub = OP ^ S_a ^ S_b.
REQ-018 Hold value: S, Flag_S, Flag_OV and Flag_INV SHALL update only in the cycle done=1, and SHALL then hold until the next done.
REQ-019 States SHALL be IDLE, CHECK, PASS1, PASS2 and FIN.
REQ-020 Transition: IDLE->CHECK on start.
REQ-021 Transition: CHECK->FIN if any digit of A or B exceeds 9, otherwise CHECK->PASS1.
REQ-022 Transition: PASS1->FIN after DIGITS digit cycles, or PASS1->PASS2 when eff_sub=1 and the final borrow is 1.
REQ-023 Transition: PASS2->FIN after DIGITS digit cycles.
REQ-024 Transition: FIN->IDLE unconditionally, with done=1 and busy=0 in FIN.
REQ-025 PASS1 SHALL process one digit per cycle, LSD first, with a 1-bit carry/borrow cleared at PASS1 entry.
REQ-026 PASS1 SHALL compute the BCD sum when eff_sub=0 and the BCD difference A-B when eff_sub=1.
REQ-027 PASS2 SHALL replace the intermediate result R by its ten's complement (0-R, digit-serial) to give |A-B|.
REQ-028 Sign rule, add: Flag_S = S_a and Flag_OV = final carry; when Flag_OV=1, S SHALL hold the low DIGITS digits.
REQ-029 Sign rule, subtract with no final borrow: Flag_S = S_a.
REQ-030 Sign rule, subtract with a final borrow: Flag_S = ~S_a.
REQ-031 Sign rule, subtract: Flag_OV = 0.
REQ-032 A zero result SHALL give Flag_S=0 (no negative zero).
REQ-033 Invalid operand: the block SHALL output Flag_INV=1, S=0, Flag_S=0 and Flag_OV=0.
REQ-034 Latency, with t = the edge accepting start: done SHALL assert at t+2 for an invalid operand.
REQ-035 Latency: done SHALL assert at t+DIGITS+2 for a single-pass operation.
REQ-036 Latency: done SHALL assert at t+2*DIGITS+2 for a two-pass operation.
REQ-037 A start held high through FIN SHALL be accepted only in the following IDLE cycle.

Reset
REQ-038 rst=1 SHALL force state IDLE, with busy=0, done=0, S=0, Flag_S=0, Flag_OV=0 and Flag_INV=0, on the next edge.
REQ-039 rst SHALL take priority over start.
REQ-040 rst asserted mid-operation SHALL abort it with no done pulse.

Structure
REQ-041 Package bcd_alu_pkg SHALL hold the state enumeration, the OP encodings (ADD=0, SUB=1) and the digit width constant (4).
REQ-042 A sub-module bcd_digit_addsub (one digit, carry/borrow in and out, add/sub select, combinational) SHALL be instantiated once and reused each digit cycle.
REQ-043 The block SHALL contain no other sub-modules.

Verification
REQ-044 Simple add, DIGITS=8: A=00000123, B=00000456, S_a=0, S_b=0, OP=0 -> S=00000579, Flag_S=0, Flag_OV=0, done at t+10.
REQ-045 Add overflow: A=99999999, B=00000001, add -> S=00000000, Flag_OV=1, Flag_S=0.
REQ-046 Negative difference: A=00000100, B=00000250, OP=1, signs 0 -> S=00000150, Flag_S=1, done at t+18.
REQ-047 No negative zero: A=00000250, S_a=1, B=00000250, S_b=1, OP=1 -> S=00000000, Flag_S=0.
REQ-048 Invalid digit: A=0000001A -> Flag_INV=1, S=0, done at t+2.
REQ-049 start during busy is ignored.
REQ-050 rst at t+4 of an add -> busy=0, all outputs 0, no done pulse.

Source files
------------

// File: rtl/bcd_alu_pkg.sv
// Shared types and constants for the digit-serial signed-magnitude BCD adder/subtractor.
package bcd_alu_pkg;

  localparam int unsigned DigitW = 4;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StPass1,
    StPass2,
    StFin
  } state_e;

  function automatic logic digit_invalid(input logic [DigitW-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of add (a+b+cin) or subtract (a-b-bin); carry/borrow out on cout_o.
module bcd_digit_addsub
  import bcd_alu_pkg::*;
(
  input  logic [DigitW-1:0] a_i,
  input  logic [DigitW-1:0] b_i,
  input  logic              cin_i,
  input  logic              sub_i,
  output logic [DigitW-1:0] s_o,
  output logic              cout_o
);

  logic [DigitW:0] sum;
  logic [DigitW:0] subtrahend;
  logic [DigitW:0] a_ext;

  always_comb begin
    a_ext      = {1'b0, a_i};
    sum        = a_ext + {1'b0, b_i} + {{DigitW{1'b0}}, cin_i};
    subtrahend = {1'b0, b_i} + {{DigitW{1'b0}}, cin_i};
    s_o        = '0;
    cout_o     = 1'b0;
    if (!sub_i) begin
      if (sum > 5'd9) begin
        s_o    = DigitW'(sum + 5'd6);
        cout_o = 1'b1;
      end else begin
        s_o = sum[DigitW-1:0];
      end
    end else begin
      if (a_ext >= subtrahend) begin
        s_o = DigitW'(a_ext - subtrahend);
      end else begin
        s_o    = DigitW'(a_ext + 5'd10 - subtrahend);
        cout_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_serial_alu.sv
// Signed-magnitude BCD add/subtract, one digit per cycle; a second pass takes the ten's
// complement when the first-pass difference borrows out.
module bcd_serial_alu
  import bcd_alu_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DigitW*DIGITS-1:0] A,
  input  logic [DigitW*DIGITS-1:0] B,
  input  logic                     S_a,
  input  logic                     S_b,
  input  logic                     OP,
  output logic                     busy,
  output logic                     done,
  output logic [DigitW*DIGITS-1:0] S,
  output logic                     Flag_S,
  output logic                     Flag_OV,
  output logic                     Flag_INV
);

  localparam int unsigned W    = DigitW * DIGITS;
  localparam int unsigned CntW = $clog2(DIGITS);

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cy_q, cy_d, sa_q, sa_d, eff_sub_q, eff_sub_d;
  logic              fs_q, fs_d, fov_q, fov_d, finv_q, finv_d;

  logic [DigitW-1:0] dig_a, dig_b, dig_s;
  logic              dig_sub, dig_co, last, any_invalid;
  logic [W-1:0]      r_next;

  // PASS2 reuses the same digit cell as 0 - R.
  assign dig_a   = (state_q == StPass2) ? '0 : a_q[DigitW-1:0];
  assign dig_b   = (state_q == StPass2) ? r_q[DigitW-1:0] : b_q[DigitW-1:0];
  assign dig_sub = (state_q == StPass2) ? 1'b1 : eff_sub_q;

  bcd_digit_addsub u_digit (
    .a_i    (dig_a),
    .b_i    (dig_b),
    .cin_i  (cy_q),
    .sub_i  (dig_sub),
    .s_o    (dig_s),
    .cout_o (dig_co)
  );

  assign r_next = {dig_s, r_q[W-1:DigitW]};
  assign last   = (cnt_q == CntW'(DIGITS - 1));

  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(a_q[DigitW*i +: DigitW]) || digit_invalid(b_q[DigitW*i +: DigitW])) begin
        any_invalid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    cy_d      = cy_q;
    sa_d      = sa_q;
    eff_sub_d = eff_sub_q;
    s_d       = s_q;
    fs_d      = fs_q;
    fov_d     = fov_q;
    finv_d    = finv_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCheck;
          a_d       = A;
          b_d       = B;
          sa_d      = S_a;
          eff_sub_d = (OP == OpSub) ^ S_a ^ S_b;
        end
      end
      StCheck: begin
        cnt_d = '0;
        cy_d  = 1'b0;
        if (any_invalid) begin
          state_d = StFin;
          s_d     = '0;
          fs_d    = 1'b0;
          fov_d   = 1'b0;
          finv_d  = 1'b1;
        end else begin
          state_d = StPass1;
        end
      end
      StPass1: begin
        a_d   = a_q >> DigitW;
        b_d   = b_q >> DigitW;
        r_d   = r_next;
        cy_d  = dig_co;
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          cnt_d = '0;
          cy_d  = 1'b0;
          if (eff_sub_q && dig_co) begin
            state_d = StPass2;
          end else begin
            state_d = StFin;
            s_d     = r_next;
            fs_d    = sa_q & (r_next != '0);
            fov_d   = ~eff_sub_q & dig_co;
            finv_d  = 1'b0;
          end
        end
      end
      StPass2: begin
        r_d   = r_next;
        cy_d  = dig_co;
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          state_d = StFin;
          s_d     = r_next;
          fs_d    = ~sa_q & (r_next != '0);
          fov_d   = 1'b0;
          finv_d  = 1'b0;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      cy_q      <= 1'b0;
      sa_q      <= 1'b0;
      eff_sub_q <= 1'b0;
      s_q       <= '0;
      fs_q      <= 1'b0;
      fov_q     <= 1'b0;
      finv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      cy_q      <= cy_d;
      sa_q      <= sa_d;
      eff_sub_q <= eff_sub_d;
      s_q       <= s_d;
      fs_q      <= fs_d;
      fov_q     <= fov_d;
      finv_q    <= finv_d;
    end
  end

  assign busy     = (state_q != StIdle) && (state_q != StFin);
  assign done     = (state_q == StFin);
  assign S        = s_q;
  assign Flag_S   = fs_q;
  assign Flag_OV  = fov_q;
  assign Flag_INV = finv_q;

endmodule
